alu_core: RTL and testbench

Registered arithmetic/logic unit that terminates the ALU stimulus interface: it samples `ce`, `inp_valid`, `mode`, `cmd`, `opa`, `opb` and `cin` on each clock and drives `res` and the flags `err`, `oflow`, `cout`, `g`, `l`, `e`. Operands may arrive in separate cycles. The block gathers them with a bounded wait and produces one registered result per completed operation. It is the design under test for the team's ALU verification environment.

---
 rtl/alu_core_if.sv | 30 +++
 rtl/alu_core.sv | 203 ++++++++++++++++++++
 tb/tb_alu_core.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// Stimulus/response bundle between the ALU core and whatever drives it.
// The master drives operands and commands; the slave (the ALU) returns result and flags.
interface alu_core_if #(
  parameter int WIDTH = 8
);
  logic             ce;
  logic [1:0]       inp_valid;
  logic             mode;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   res;
  logic             err;
  logic             oflow;
  logic             cout;
  logic             g;
  logic             l;
  logic             e;

  modport master (
    output ce, inp_valid, mode, cmd, opa, opb, cin,
    input  res, err, oflow, cout, g, l, e
  );

  modport slave (
    input  ce, inp_valid, mode, cmd, opa, opb, cin,
    output res, err, oflow, cout, g, l, e
  );
endinterface

// File: rtl/alu_core.sv
// Registered ALU that gathers split operands with a bounded 16-cycle wait
// and registers one result (or error) per completed operation.
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  typedef struct packed {
    logic [WIDTH:0] res;
    logic           err;
    logic           oflow;
    logic           cout;
    logic           g;
    logic           l;
    logic           e;
  } result_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             haveA_q;
  logic [WIDTH-1:0] held_q;
  logic             heldMode_q;
  logic [3:0]       heldCmd_q;
  logic             heldCin_q;
  result_t          out_q;

  logic             selMode;
  logic [3:0]       selCmd;
  logic             selCin;
  logic [WIDTH-1:0] selA;
  logic [WIDTH-1:0] selB;
  logic             needA;
  logic             needB;
  logic             covered;
  logic             partial;
  logic             waitDone;
  logic [WIDTH:0]   aExt;
  logic [WIDTH:0]   bExt;
  logic [WIDTH:0]   cinExt;
  logic [2*WIDTH-1:0] rotL;
  logic [2*WIDTH-1:0] rotR;
  result_t          result_d;
  result_t          errRes;

  // In WAIT the latched command is used; the latched operand fills in
  // the missing side unless both arrive fresh.
  always_comb begin
    selMode = bus.mode;
    selCmd  = bus.cmd;
    selCin  = bus.cin;
    selA    = bus.opa;
    selB    = bus.opb;
    if (state_q == ST_WAIT) begin
      selMode = heldMode_q;
      selCmd  = heldCmd_q;
      selCin  = heldCin_q;
      if (bus.inp_valid != 2'b11) begin
        if (haveA_q) selA = held_q;
        else         selB = held_q;
      end
    end
  end

  always_comb begin
    needA = 1'b0;
    needB = 1'b0;
    if (bus.mode) begin
      case (bus.cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8: begin needA = 1'b1; needB = 1'b1; end
        4'd4, 4'd5:                   needA = 1'b1;
        4'd6, 4'd7:                   needB = 1'b1;
        default: ;
      endcase
    end else begin
      case (bus.cmd)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: begin needA = 1'b1; needB = 1'b1; end
        4'd6, 4'd8, 4'd9:                                 needA = 1'b1;
        4'd7, 4'd10, 4'd11:                               needB = 1'b1;
        default: ;
      endcase
    end
  end

  // Unused commands need nothing, so any non-empty inp_valid reaches the error result.
  assign covered  = (bus.inp_valid != 2'b00) && ((bus.inp_valid & {needB, needA}) == {needB, needA});
  assign partial  = needA && needB && (bus.inp_valid != 2'b00) && !covered;
  assign waitDone = (bus.inp_valid == 2'b11) || (haveA_q ? bus.inp_valid[1] : bus.inp_valid[0]);

  always_comb begin
    errRes     = '0;
    errRes.err = 1'b1;
  end

  always_comb begin
    result_d = '0;
    aExt     = {1'b0, selA};
    bExt     = {1'b0, selB};
    cinExt   = {{WIDTH{1'b0}}, selCin};
    rotL     = {selA, selA} << selB[SHW-1:0];
    rotR     = {selA, selA} >> selB[SHW-1:0];
    if (selMode) begin
      case (selCmd)
        4'd0: begin result_d.res = aExt + bExt;          result_d.cout  = result_d.res[WIDTH]; end
        4'd1: begin result_d.res = aExt - bExt;          result_d.oflow = aExt < bExt; end
        4'd2: begin result_d.res = aExt + bExt + cinExt; result_d.cout  = result_d.res[WIDTH]; end
        4'd3: begin result_d.res = aExt - bExt - cinExt; result_d.oflow = aExt < (bExt + cinExt); end
        4'd4: begin result_d.res = aExt + ONE;           result_d.cout  = &selA; end
        4'd5: begin result_d.res = aExt - ONE;           result_d.oflow = (selA == '0); end
        4'd6: begin result_d.res = bExt + ONE;           result_d.cout  = &selB; end
        4'd7: begin result_d.res = bExt - ONE;           result_d.oflow = (selB == '0); end
        4'd8: begin
          result_d.g = selA > selB;
          result_d.l = selA < selB;
          result_d.e = selA == selB;
        end
        default: result_d.err = 1'b1;
      endcase
    end else begin
      case (selCmd)
        4'd0:  result_d.res = {1'b0, selA & selB};
        4'd1:  result_d.res = {1'b0, ~(selA & selB)};
        4'd2:  result_d.res = {1'b0, selA | selB};
        4'd3:  result_d.res = {1'b0, ~(selA | selB)};
        4'd4:  result_d.res = {1'b0, selA ^ selB};
        4'd5:  result_d.res = {1'b0, ~(selA ^ selB)};
        4'd6:  result_d.res = {1'b0, ~selA};
        4'd7:  result_d.res = {1'b0, ~selB};
        4'd8:  result_d.res = {1'b0, selA >> 1};
        4'd9:  result_d.res = {1'b0, selA << 1};
        4'd10: result_d.res = {1'b0, selB >> 1};
        4'd11: result_d.res = {1'b0, selB << 1};
        4'd12: begin
          result_d.res = {1'b0, rotL[2*WIDTH-1:WIDTH]};
          result_d.err = |selB[WIDTH-1:SHW];
        end
        4'd13: begin
          result_d.res = {1'b0, rotR[WIDTH-1:0]};
          result_d.err = |selB[WIDTH-1:SHW];
        end
        default: result_d.err = 1'b1;
      endcase
    end
  end

  // Counter reaching 15 without completion means this is the 16th WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      haveA_q    <= 1'b0;
      held_q     <= '0;
      heldMode_q <= 1'b0;
      heldCmd_q  <= '0;
      heldCin_q  <= 1'b0;
      out_q      <= '0;
    end else if (bus.ce) begin
      case (state_q)
        ST_IDLE: begin
          if (covered) begin
            out_q <= result_d;
          end else if (partial) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            haveA_q    <= bus.inp_valid[0];
            held_q     <= bus.inp_valid[0] ? bus.opa : bus.opb;
            heldMode_q <= bus.mode;
            heldCmd_q  <= bus.cmd;
            heldCin_q  <= bus.cin;
          end else begin
            out_q <= errRes;
          end
        end
        ST_WAIT: begin
          if (waitDone) begin
            out_q   <= result_d;
            state_q <= ST_IDLE;
          end else if (cnt_q == 4'd15) begin
            out_q   <= errRes;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.res   = out_q.res;
  assign bus.err   = out_q.err;
  assign bus.oflow = out_q.oflow;
  assign bus.cout  = out_q.cout;
  assign bus.g     = out_q.g;
  assign bus.l     = out_q.l;
  assign bus.e     = out_q.e;
endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: each scenario task drives vectors and checks
// res plus the packed flag set {err,oflow,cout,g,l,e} against hand-computed values.
module tb_alu_core;
  localparam logic AR = 1'b1;
  localparam logic LG = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nBad = 0;

  alu_core_if #(.WIDTH(8)) bus ();

  alu_core #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {bus.err, bus.oflow, bus.cout, bus.g, bus.l, bus.e};
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic ceV, input logic [1:0] iv, input logic m,
                               input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                               input logic ci);
    bus.ce        = ceV;
    bus.inp_valid = iv;
    bus.mode      = m;
    bus.cmd       = c;
    bus.opa       = a;
    bus.opb       = b;
    bus.cin       = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1, 2'b00, AR, 0, 8'h00, 8'h00, 0);
    applyStimulus(1, 2'b00, AR, 0, 8'h00, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL reset_state: res=%h flags=%b want res=000 flags=000000", bus.res, flags());
    end
    rst = 1'b0;
    applyStimulus(1, 2'b01, AR, 0, 8'h05, 8'h00, 0);
    rst = 1'b1;
    applyStimulus(1, 2'b00, AR, 0, 8'h00, 8'h00, 0);
    rst = 1'b0;
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL reset_mid_wait: res=%h flags=%b want res=000 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b10, AR, 0, 8'h00, 8'h03, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL abandoned_op: res=%h flags=%b want res=000 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b01, AR, 0, 8'h10, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h013 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL post_reset_add: res=%h flags=%b want res=013 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b01, AR, 4, 8'h41, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h042 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL post_reset_inc_a: res=%h flags=%b want res=042 flags=000000", bus.res, flags());
    end
  endtask

  task automatic test_full_add();
    applyStimulus(1, 2'b11, AR, 2, 8'hFF, 8'h01, 1);
    nCmp++;
    if (bus.res !== 9'h101 || flags() !== 6'b001000) begin
      nBad++; $display("[TB] FAIL full_add: res=%h flags=%b want res=101 flags=001000", bus.res, flags());
    end
  endtask

  task automatic test_arith();
    applyStimulus(1, 2'b11, AR, 1, 8'h03, 8'h05, 0);
    nCmp++;
    if (bus.res !== 9'h1FE || flags() !== 6'b010000) begin
      nBad++; $display("[TB] FAIL sub_borrow: res=%h flags=%b want res=1fe flags=010000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 8, 8'h7A, 8'h7A, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b000001) begin
      nBad++; $display("[TB] FAIL cmp_eq: res=%h flags=%b want res=000 flags=000001", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 8, 8'h80, 8'h7F, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b000100) begin
      nBad++; $display("[TB] FAIL cmp_gt: res=%h flags=%b want res=000 flags=000100", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 8, 8'h01, 8'h02, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b000010) begin
      nBad++; $display("[TB] FAIL cmp_lt: res=%h flags=%b want res=000 flags=000010", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 3, 8'h10, 8'h05, 1);
    nCmp++;
    if (bus.res !== 9'h00A || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL sub_cin: res=%h flags=%b want res=00a flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b10, AR, 7, 8'h55, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h1FF || flags() !== 6'b010000) begin
      nBad++; $display("[TB] FAIL dec_b_zero: res=%h flags=%b want res=1ff flags=010000", bus.res, flags());
    end
    applyStimulus(1, 2'b01, AR, 4, 8'hFF, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h100 || flags() !== 6'b001000) begin
      nBad++; $display("[TB] FAIL inc_a_ones: res=%h flags=%b want res=100 flags=001000", bus.res, flags());
    end
  endtask

  task automatic test_logic();
    applyStimulus(1, 2'b11, LG, 1, 8'hF0, 8'hCC, 0);
    nCmp++;
    if (bus.res !== 9'h03F || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL nand: res=%h flags=%b want res=03f flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b01, LG, 9, 8'h81, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h002 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL shl1_a: res=%h flags=%b want res=002 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b10, LG, 10, 8'h00, 8'h81, 0);
    nCmp++;
    if (bus.res !== 9'h040 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL shr1_b: res=%h flags=%b want res=040 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, LG, 13, 8'h81, 8'h01, 0);
    nCmp++;
    if (bus.res !== 9'h0C0 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL ror: res=%h flags=%b want res=0c0 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, LG, 14, 8'h12, 8'h34, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b100000) begin
      nBad++; $display("[TB] FAIL bad_logic_cmd: res=%h flags=%b want res=000 flags=100000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, LG, 0, 8'h12, 8'h34, 0);
    applyStimulus(1, 2'b00, LG, 0, 8'h12, 8'h34, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b100000) begin
      nBad++; $display("[TB] FAIL no_operands: res=%h flags=%b want res=000 flags=100000", bus.res, flags());
    end
  endtask

  task automatic test_split();
    applyStimulus(1, 2'b11, LG, 0, 8'hAA, 8'h0F, 0);
    applyStimulus(1, 2'b01, LG, 4, 8'hF0, 8'h00, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 2'b00, AR, 9, 8'h00, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h00A || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL split_hold: res=%h flags=%b want res=00a flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b10, AR, 0, 8'h00, 8'h0F, 0);
    nCmp++;
    if (bus.res !== 9'h0FF || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL split_result: res=%h flags=%b want res=0ff flags=000000", bus.res, flags());
    end
  endtask

  task automatic test_timeout();
    applyStimulus(1, 2'b01, LG, 0, 8'h3C, 8'h00, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b00, LG, 0, 8'h00, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h0FF || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL timeout_pending: res=%h flags=%b want res=0ff flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b00, LG, 0, 8'h00, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b100000) begin
      nBad++; $display("[TB] FAIL timeout_err: res=%h flags=%b want res=000 flags=100000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, LG, 2, 8'h0F, 8'hF0, 0);
    nCmp++;
    if (bus.res !== 9'h0FF || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL after_timeout: res=%h flags=%b want res=0ff flags=000000", bus.res, flags());
    end
  endtask

  task automatic test_ce_rotate();
    applyStimulus(1, 2'b11, LG, 12, 8'h81, 8'h10, 0);
    nCmp++;
    if (bus.res !== 9'h081 || flags() !== 6'b100000) begin
      nBad++; $display("[TB] FAIL rol_range_err: res=%h flags=%b want res=081 flags=100000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, LG, 12, 8'h81, 8'h01, 0);
    nCmp++;
    if (bus.res !== 9'h003 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL rol: res=%h flags=%b want res=003 flags=000000", bus.res, flags());
    end
    applyStimulus(0, 2'b11, AR, 0, 8'h11, 8'h22, 0);
    nCmp++;
    if (bus.res !== 9'h003 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL ce_idle_hold: res=%h flags=%b want res=003 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b01, AR, 1, 8'h09, 8'h00, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b11, AR, 0, 8'h01, 8'h01, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b00, AR, 0, 8'h00, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h003 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL ce_extends_wait: res=%h flags=%b want res=003 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b00, AR, 0, 8'h00, 8'h00, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b100000) begin
      nBad++; $display("[TB] FAIL ce_timeout: res=%h flags=%b want res=000 flags=100000", bus.res, flags());
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 2'b11, AR, 0, 8'h10, 8'h20, 0);
    nCmp++;
    if (bus.res !== 9'h030 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL b2b_add: res=%h flags=%b want res=030 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, LG, 2, 8'h0F, 8'h30, 0);
    nCmp++;
    if (bus.res !== 9'h03F || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL b2b_or: res=%h flags=%b want res=03f flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b10, AR, 6, 8'h00, 8'h7F, 0);
    nCmp++;
    if (bus.res !== 9'h080 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL b2b_inc_b: res=%h flags=%b want res=080 flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 0, 8'h80, 8'h80, 0);
    nCmp++;
    if (bus.res !== 9'h100 || flags() !== 6'b001000) begin
      nBad++; $display("[TB] FAIL b2b_add_carry: res=%h flags=%b want res=100 flags=001000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 9, 8'h80, 8'h80, 0);
    nCmp++;
    if (bus.res !== 9'h000 || flags() !== 6'b100000) begin
      nBad++; $display("[TB] FAIL b2b_bad_arith_cmd: res=%h flags=%b want res=000 flags=100000", bus.res, flags());
    end
    applyStimulus(1, 2'b01, LG, 4, 8'hAA, 8'h00, 0);
    applyStimulus(1, 2'b10, LG, 0, 8'h00, 8'h55, 0);
    nCmp++;
    if (bus.res !== 9'h0FF || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL b2b_split_xor: res=%h flags=%b want res=0ff flags=000000", bus.res, flags());
    end
    applyStimulus(1, 2'b11, AR, 0, 8'h01, 8'h01, 0);
    nCmp++;
    if (bus.res !== 9'h002 || flags() !== 6'b000000) begin
      nBad++; $display("[TB] FAIL b2b_after_split: res=%h flags=%b want res=002 flags=000000", bus.res, flags());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ce        = 1'b0;
    bus.inp_valid = 2'b00;
    bus.mode      = 1'b0;
    bus.cmd       = 4'd0;
    bus.opa       = 8'h00;
    bus.opb       = 8'h00;
    bus.cin       = 1'b0;
    test_reset();
    test_full_add();
    test_arith();
    test_logic();
    test_split();
    test_timeout();
    test_ce_rotate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
